// File: rtl/data_modulate_5x5_ctrl_pkg.sv
// Shared types for the 5x5 window modulator controller: FSM state encoding, counter widths, increment helper.
package data_modulate_pkg;

  localparam int CNT_W   = 10;
  localparam int SHIFT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] plus_1(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/data_modulate_5x5_ctrl_if.sv
// Pixel-in / window-out handshake between the controller (master) and line buffer / datapath / sink (slave).
interface data_modulate_5x5_ctrl_if;
  import data_modulate_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic             out_ready_i;
  logic             shift_en_o;
  logic             zero_fill_o;
  logic             win_valid_o;
  logic [CNT_W-1:0] row_o;
  logic [CNT_W-1:0] col_o;

  modport master (
    input  in_valid_i, out_ready_i,
    output in_ready_o, shift_en_o, zero_fill_o, win_valid_o, row_o, col_o
  );

  modport slave (
    output in_valid_i, out_ready_i,
    input  in_ready_o, shift_en_o, zero_fill_o, win_valid_o, row_o, col_o
  );

endinterface

// File: rtl/data_modulate_5x5_ctrl_raster_counter.sv
// Row/column raster position counter: col wraps COLS-1 -> 0 and bumps row, row wraps ROWS-1 -> 0.
module raster_counter
  import data_modulate_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col
);

  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : plus_1(row);
      end else begin
        col <= plus_1(col);
      end
    end
  end

endmodule

// File: rtl/data_modulate_5x5_ctrl.sv
// Sequencer for the 5x5 window modulator: fill, run, zero-fed flush, one window per pixel.
// Optional downstream backpressure when DATA_MODULATE_CTRL_BACKPRESSURE_EN is defined.
module data_modulate_5x5_ctrl
  import data_modulate_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 7,
  parameter int LAG  = 2*COLS + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start_i,
  output logic                     busy_o,
  output logic                     frame_done_o,
  data_modulate_5x5_ctrl_if.master io
);

  localparam logic [SHIFT_W-1:0] LAG_C     = SHIFT_W'(LAG);
  localparam logic [SHIFT_W-1:0] LAG_M1    = SHIFT_W'(LAG - 1);
  localparam logic [SHIFT_W-1:0] NPIX_M1   = SHIFT_W'(ROWS*COLS - 1);
  localparam logic [SHIFT_W-1:0] TOTAL_C   = SHIFT_W'(ROWS*COLS + LAG);

  state_t             state, state_nx;
  logic [SHIFT_W-1:0] shift_cnt;
  logic               ds_ok;
  logic               in_fire;
  logic               flush_tick;
  logic               win_vld_q;
  logic               frame_arm;

`ifdef DATA_MODULATE_CTRL_BACKPRESSURE_EN
  assign ds_ok = io.out_ready_i;
`else
  logic unused_out_ready;
  assign unused_out_ready = io.out_ready_i;
  assign ds_ok = 1'b1;
`endif

  assign frame_arm     = (state == ST_IDLE) && frame_start_i;
  assign in_fire       = io.in_valid_i && io.in_ready_o;
  assign io.shift_en_o = in_fire || flush_tick;
  assign io.win_valid_o = win_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // FLUSH lingers one cycle past the last shift so the final window is emitted before DONE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (frame_start_i) state_nx = ST_FILL;
      ST_FILL:  if (in_fire && shift_cnt == LAG_M1) state_nx = ST_RUN;
      ST_RUN:   if (in_fire && shift_cnt == NPIX_M1) state_nx = ST_FLUSH;
      ST_FLUSH: if (shift_cnt == TOTAL_C) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready_o  = 1'b0;
    io.zero_fill_o = 1'b0;
    busy_o         = 1'b0;
    frame_done_o   = 1'b0;
    flush_tick     = 1'b0;
    case (state)
      ST_FILL: begin
        io.in_ready_o = 1'b1;
        busy_o        = 1'b1;
      end
      ST_RUN: begin
        io.in_ready_o = ds_ok;
        busy_o        = 1'b1;
      end
      ST_FLUSH: begin
        busy_o         = 1'b1;
        io.zero_fill_o = (shift_cnt != TOTAL_C);
        flush_tick     = (shift_cnt != TOTAL_C) && ds_ok;
      end
      ST_DONE: frame_done_o = 1'b1;
      default: ;
    endcase
  end

  // A shift whose pre-increment count is at least LAG pushes a complete window centre into place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= '0;
      win_vld_q <= 1'b0;
    end else begin
      win_vld_q <= io.shift_en_o && (shift_cnt >= LAG_C);
      if (frame_arm)
        shift_cnt <= '0;
      else if (io.shift_en_o)
        shift_cnt <= shift_cnt + SHIFT_W'(1);
    end
  end

  raster_counter #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_win_pos (
    .clk(clk),
    .rst(rst),
    .clr(frame_arm),
    .en (win_vld_q),
    .row(io.row_o),
    .col(io.col_o)
  );

endmodule

// File: tb/tb_data_modulate_5x5_ctrl.sv
// Frame-level bench for data_modulate_5x5_ctrl: table of frame scenarios plus reset and hold sequences.
module tb_data_modulate_5x5_ctrl;

  localparam int ROWS = 7;
  localparam int COLS = 7;
  localparam int LAG  = 2*COLS + 2;
  localparam int NPIX = ROWS*COLS;
`ifdef DATA_MODULATE_CTRL_BACKPRESSURE_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;

  data_modulate_5x5_ctrl_if io();

  data_modulate_5x5_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(frame_start),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .io           (io)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; } win_t;
  typedef struct {
    string name;
    int    gap_pct;
    bit    mid_start;
    bit    hold;
    bit    rand_oready;
    int    exp_win;
    int    exp_flush;
    int    exp_done;
    int    exp_lat;
  } vec_t;

  vec_t vecs[5];
  win_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc, win_cnt, flush_shifts, done_cnt, first_fire, lat, last_win;
  bit   prev_shift;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    acc = 0; win_cnt = 0; flush_shifts = 0; done_cnt = 0;
    first_fire = -1; lat = -1; last_win = -100; prev_shift = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   int'(io.in_ready_o),  0);
    chk({tag, "_shift_en"},   int'(io.shift_en_o),  0);
    chk({tag, "_zero_fill"},  int'(io.zero_fill_o), 0);
    chk({tag, "_win_valid"},  int'(io.win_valid_o), 0);
    chk({tag, "_row"},        int'(io.row_o),       0);
    chk({tag, "_col"},        int'(io.col_o),       0);
    chk({tag, "_busy"},       int'(busy),           0);
    chk({tag, "_frame_done"}, int'(frame_done),     0);
  endtask

  // Each accepted pixel k owns window k in raster order; its coordinates are queued on acceptance.
  task automatic monitor();
    win_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (io.in_valid_i && io.in_ready_o) begin
          chk("shift_on_fire", int'(io.shift_en_o), 1);
          e.r = acc / COLS;
          e.c = acc % COLS;
          q.push_back(e);
          if (acc == 0) first_fire = cyc;
          acc++;
        end
        if (io.win_valid_o) begin
          chk("win_after_shift", int'(prev_shift), 1);
          chk("win_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("win_row", int'(io.row_o), e.r);
            chk("win_col", int'(io.col_o), e.c);
          end
          if (win_cnt == 0) lat = cyc - first_fire;
          win_cnt++;
          last_win = cyc;
        end
        if (io.zero_fill_o) begin
          chk("ready_low_in_flush", int'(io.in_ready_o), 0);
          if (io.shift_en_o) flush_shifts++;
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_after_last_win", cyc - last_win, 1);
        end
        prev_shift = io.shift_en_o;
      end else begin
        prev_shift = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    bit pulsed = 1'b0;
    bit held   = 1'b0;
    int hold_idx = -1;
`ifdef DATA_MODULATE_CTRL_BACKPRESSURE_EN
    int fr = 0, fc = 0;
`endif
    reset_model();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      io.in_valid_i  = ($urandom_range(99) >= v.gap_pct);
      io.out_ready_i = v.rand_oready ? ($urandom_range(3) != 0) : 1'b1;
      frame_start    = 1'b0;
      if (v.mid_start && !pulsed && acc == 20) begin
        frame_start = 1'b1;
        pulsed = 1'b1;
      end
      if (v.hold && !held && win_cnt == 3*COLS + 2) begin
        held = 1'b1;
        hold_idx = 0;
      end
      if (hold_idx >= 0) io.out_ready_i = 1'b0;
      @(negedge clk);
      if (hold_idx >= 0) begin
        chk("hold_in_ready", int'(io.in_ready_o), 1 - BP);
`ifdef DATA_MODULATE_CTRL_BACKPRESSURE_EN
        chk("hold_shift_en", int'(io.shift_en_o), 0);
        if (hold_idx == 1) begin
          fr = int'(io.row_o);
          fc = int'(io.col_o);
        end else if (hold_idx > 1) begin
          chk("hold_row_frozen", int'(io.row_o), fr);
          chk("hold_col_frozen", int'(io.col_o), fc);
        end
`endif
        hold_idx = (hold_idx == 4) ? -1 : hold_idx + 1;
      end
      @(posedge clk); #1;
    end
    chk({v.name, "_done_seen"}, int'(done_cnt > 0), 1);
    io.in_valid_i  = 1'b0;
    io.out_ready_i = 1'b1;
    frame_start    = 1'b0;
    repeat (4) @(negedge clk);
    chk({v.name, "_windows"},     win_cnt,      v.exp_win);
    chk({v.name, "_flush_shift"}, flush_shifts, v.exp_flush);
    chk({v.name, "_done_pulses"}, done_cnt,     v.exp_done);
    chk({v.name, "_queue_left"},  q.size(),     0);
    if (v.exp_lat >= 0) chk({v.name, "_first_lat"}, lat, v.exp_lat);
    chk({v.name, "_idle_busy"},   int'(busy),         0);
    chk({v.name, "_idle_ready"},  int'(io.in_ready_o), 0);
    chk({v.name, "_end_row"},     int'(io.row_o),     0);
    chk({v.name, "_end_col"},     int'(io.col_o),     0);
  endtask

  initial begin
    bit hit;
    io.in_valid_i  = 1'b0;
    io.out_ready_i = 1'b1;
    vecs[0] = '{"contig",    0, 1'b0, 1'b0, 1'b0, NPIX, LAG, 1, LAG + 1};
    vecs[1] = '{"gaps30",   30, 1'b0, 1'b0, 1'b0, NPIX, LAG, 1, -1};
    vecs[2] = '{"mid_start", 0, 1'b1, 1'b0, 1'b0, NPIX, LAG, 1, LAG + 1};
    vecs[3] = '{"hold5",     0, 1'b0, 1'b1, 1'b0, NPIX, LAG, 1, LAG + 1};
    vecs[4] = '{"rand_ordy",20, 1'b0, 1'b0, 1'b1, NPIX, LAG, 1, -1};
    reset_model();
    fork
      monitor();
    join_none

    #1 chk_all_zero("in_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Asynchronous reset while window (3,4) is on the outputs.
    reset_model();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    io.in_valid_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (io.win_valid_o && io.row_o == 10'd3 && io.col_o == 10'd4) hit = 1'b1;
    end
    chk("reset_point_reached", int'(hit), 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    io.in_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_no_done", done_cnt, 0);
    chk_all_zero("post_reset_idle");
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_modulate_5x5_ctrl.md
# data_modulate_5x5_ctrl

Sequencer for the 5x5 window modulator datapath: accepts a raster pixel stream, tracks line-buffer fill, and drives the datapath shift enable (`start`) and window-valid strobe (`done_o`). Drains the last two rows and two columns with zero-fed shifts so every pixel of a ROWS x COLS frame produces exactly one window. Supplies the row/column of the current window centre for debug and downstream tagging. Sits between the line-buffer/input FIFO and the `Data_modulate_5x5_datapath` instance.

## Interface
- ROWS, 7, frame height in pixels (3..1023)
- COLS, 7, frame width in pixels (3..1023)
- LAG, 2*COLS+2, shifts between a pixel entering and its window centre reaching `data12`
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- frame_start_i  input  1  one-cycle pulse; arms a new frame (ignored unless IDLE)
- in_valid_i  input  1  input pixel present on the line-buffer taps
- in_ready_o  output  1  controller accepts a pixel this cycle
- out_ready_i  output-side  input  1  downstream can take a window
- shift_en_o  output  1  to datapath `start`; one column shift
- zero_fill_o  output  1  line-buffer tap mux selects 0 (flush shifts)
- win_valid_o  output  1  to datapath `done_o`; window at (row_o, col_o) valid
- row_o  output  10  window centre row
- col_o  output  10  window centre column
- busy_o  output  1  high in FILL, RUN, FLUSH
- frame_done_o  output  1  one-cycle pulse after last window accepted

## Operation
- States: IDLE, FILL, RUN, FLUSH, DONE.
- IDLE: in_ready_o=0. frame_start_i -> FILL; clear shift_cnt (20 bit), row/col counters.
- FILL: in_ready_o=1; each in_valid_i&in_ready_o (in_fire) asserts shift_en_o same cycle, shift_cnt++. When shift_cnt reaches LAG -> RUN.
- RUN: in_ready_o = out_ready_i-gated (see Configuration). Each in_fire shifts; each shift with shift_cnt >= LAG produces win_valid_o next cycle. When ROWS*COLS inputs accepted -> FLUSH.
- FLUSH: no input accepted; zero_fill_o=1; one shift per cycle when downstream ready, until shift_cnt = ROWS*COLS+LAG -> DONE.
- DONE: frame_done_o=1 for one cycle -> IDLE.
- Window counters: col_o advances on each win_valid_o, wraps COLS-1 -> 0 and increments row_o; row_o wraps ROWS-1 -> 0 at frame end. First window (0,0).
- Exactly ROWS*COLS win_valid_o pulses per frame; never a window for shift_cnt < LAG.
- Zero padding of edges is done by the datapath from row_o/col_o; controller only guarantees counters match the window in `data0..data24`.
- frame_start_i while busy: ignored, no error.
- Reset mid-frame: all state to IDLE, counters 0, no frame_done_o.

## Timing
- All outputs reset to 0 (IDLE).
- shift_en_o combinational from in_fire (FILL/RUN) or flush tick (FLUSH); datapath registers update on that edge.
- win_valid_o registered: asserted the cycle after the qualifying shift, held for exactly one cycle; row_o/col_o stable while it is high, update the following cycle.
- Throughput: one window per cycle with in_valid_i and out_ready_i high.
- Latency: first win_valid_o LAG+1 cycles after first in_fire (back-to-back input); last frame_done_o one cycle after last win_valid_o.
- shift_en_o and win_valid_o never asserted in IDLE or DONE.

## Configuration
- DATA_MODULATE_CTRL_BACKPRESSURE_EN defined: in RUN, in_ready_o = out_ready_i; FLUSH shifts only when out_ready_i; a withheld out_ready_i freezes shift_cnt and counters.
- Undefined: out_ready_i ignored; in_ready_o=1 in FILL/RUN, FLUSH shifts every cycle; downstream must always accept.

## Structure
- Shared package `data_modulate_pkg`: state encoding typedef, counter width constant (10), shift-count width (20).
- One sub-module natural: `raster_counter` (row/col wrap counter, enable input, parameters ROWS/COLS), reused for window position; the existing `plus_1` may be used inside it.

## Test plan
- ROWS=COLS=7, continuous in_valid_i, out_ready_i=1 -> first win_valid_o 17 cycles after first in_fire at (0,0); 49 windows; frame_done_o one cycle after (6,6).
- Random in_valid_i gaps (30% idle) -> same 49 windows, in raster order, no window without preceding shift.
- With BACKPRESSURE_EN, out_ready_i low for 5 cycles mid-row 3 -> in_ready_o low, shift_en_o low, col_o/row_o frozen; resumes with no lost/duplicated window.
- FLUSH: after 49th input, zero_fill_o high for exactly 16 shifts; in_ready_o 0 throughout.
- rst asserted at window (3,4) -> all outputs 0 immediately (async); new frame_start_i restarts at (0,0) with full 49 windows.
- frame_start_i pulsed during RUN -> ignored; window count still 49, single frame_done_o.
